neural_soc_hw_port_bank: RTL
============================

# neural_soc_hw_port_bank

Multi-channel, parametrised Avalon-MM output port bank for the neural SoC. It replaces single-word software-to-hardware output ports with NUM_CHANNELS independent shadow registers. Each channel's value is delivered to the hardware datapath through a valid/ack handshake, and overrun detection plus status are visible to software. It sits between the Nios/Avalon interconnect and the neural-network accelerator's input staging logic.

## Interface
- DATA_WIDTH, 32, width of each channel word and of the Avalon data bus
- NUM_CHANNELS, 4, number of independent output channels (1..16)
- ADDR_WIDTH, 3, Avalon word-address width; must satisfy 2**ADDR_WIDTH >= NUM_CHANNELS+2
- clk  input  1  sole clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- address  input  ADDR_WIDTH  Avalon word address
- chipselect  input  1  slave select; read/write ignored when low
- read  input  1  read strobe
- write  input  1  write strobe (active-high)
- writedata  input  DATA_WIDTH  write data
- readdata  output  DATA_WIDTH  registered read data, read latency 1
- out_data  output  NUM_CHANNELS*DATA_WIDTH  committed channel words; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  output  NUM_CHANNELS  per-channel transfer valid
- out_ack  input  NUM_CHANNELS  per-channel acknowledge from hardware

## Operation
- Register map (word addresses, N = NUM_CHANNELS):
  - 0..N-1: SHADOW[i]. Read/write. Holds the staged value; never drives out_data directly.
  - N: COMMIT. Write-only; reads return 0. Writing bit i=1 requests commit of channel i. Bits >= N are ignored.
  - N+1: STATUS. Bits [N-1:0] are BUSY (= out_valid). Bits [2N-1:N] are OVERRUN (sticky). Upper bits read 0. Writing 1 to bit N+i clears OVERRUN[i]. Writes to BUSY bits are ignored.
  - Addresses > N+1: writes ignored, reads return 0.
- An access occurs only when chipselect is high. If read and write are both high, the write is performed and readdata returns the pre-write value.
- Per-channel FSM, two states:
  - IDLE, with out_valid=0:
    - A commit bit copies SHADOW[i] into out_data[i] and moves the channel to BUSY.
    - out_ack is ignored.
  - BUSY, with out_valid=1:
    - out_ack[i] high at a clock edge returns the channel to IDLE.
    - A commit bit in BUSY is dropped and sets OVERRUN[i]. out_data[i] is unchanged.
- Decisions use the state at the start of the cycle. Commit and ack in the same cycle on a BUSY channel: the channel goes to IDLE and OVERRUN[i] is set. The new commit is not accepted.
- A SHADOW write while BUSY is allowed and does not disturb out_data.
- OVERRUN set and a W1C clear in the same cycle: set wins.
- Channels are fully independent. One COMMIT write may start several channels at once.
- Reset:
  - SHADOW, out_data and readdata are 0.
  - out_valid is 0, all channels are IDLE, OVERRUN is 0.
  - Reset mid-handshake drops out_valid at the next edge with no completion recorded.

## Timing
- Commit write sampled at edge T: out_valid[i] and the new out_data[i] are visible after edge T.
- Ack sampled high at edge T+k (k >= 1): out_valid[i] is low after that edge. The minimum valid pulse is 1 cycle when ack is already high.
- Back-to-back transfer: a commit in the cycle after the ack edge is accepted.
- out_data[i] is stable for the whole BUSY interval.
- Read at edge T: readdata is valid after T and holds its value until the next read.
- STATUS reflects state after the previous edge. A commit written at T reads BUSY=1 from a read issued at T+1.

## Test plan
- Reset, then read all addresses:
  - readdata = 0 everywhere.
  - out_valid = 0, out_data = 0.
- Write SHADOW[2]=0xDEADBEEF, then COMMIT=0x4, with out_ack low:
  - out_valid = 0b0100 one cycle after the commit.
  - out_data channel 2 = 0xDEADBEEF.
  - STATUS = 0x4.
  - Pulse out_ack[2] for one cycle: out_valid returns to 0.
- Channel 0 BUSY, write SHADOW[0]=0x1234 then COMMIT=0x1:
  - out_data channel 0 keeps its old value.
  - STATUS = 0x11.
  - Write STATUS=0x10: STATUS = 0x01.
- Commit and out_ack on a BUSY channel in the same cycle:
  - Channel goes IDLE and OVERRUN is set.
  - A commit on the next cycle is accepted with the latest SHADOW value.
- out_ack[1:0] held high permanently, COMMIT=0x3:
  - out_valid=0b11 for exactly one cycle.
  - No overrun.
- Assert reset while channels 0 and 3 are BUSY:
  - All outputs are 0 after the next edge.
  - STATUS = 0.

Source files
------------

// File: rtl/neural_soc_hw_port_bank.sv
// Avalon-MM bank of NUM_CHANNELS shadow registers; COMMIT publishes a shadow word to hardware
// through a per-channel valid/ack handshake, and STATUS exposes BUSY plus sticky OVERRUN.
module neural_soc_hw_port_bank #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic                             chipselect,
  input  logic                             read,
  input  logic                             write,
  input  logic [DATA_WIDTH-1:0]            writedata,
  output logic [DATA_WIDTH-1:0]            readdata,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CHANNELS-1:0]          out_valid,
  input  logic [NUM_CHANNELS-1:0]          out_ack
);
  localparam int N = NUM_CHANNELS;
  localparam logic [ADDR_WIDTH-1:0] COMMIT_ADDR = ADDR_WIDTH'(N);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(N + 1);

  typedef enum logic {IDLE, BUSY} ch_state_e;

  ch_state_e             state_q    [N];
  logic [DATA_WIDTH-1:0] shadow_q   [N];
  logic [DATA_WIDTH-1:0] data_q     [N];
  logic [N-1:0]          valid_q;
  logic [N-1:0]          overrun_q;
  logic [DATA_WIDTH-1:0] readdata_q;

  logic                  wr_en;
  logic                  rd_en;
  logic [N-1:0]          commit;
  logic [N-1:0]          ovr_clr;
  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] rd_d;

  always_comb begin
    wr_en   = chipselect & write;
    rd_en   = chipselect & read;
    commit  = (wr_en && address == COMMIT_ADDR) ? writedata[N-1:0] : '0;
    ovr_clr = (wr_en && address == STATUS_ADDR) ? writedata[2*N-1:N] : '0;

    status          = '0;
    status[N-1:0]   = valid_q;
    status[2*N-1:N] = overrun_q;

    // Read mux samples pre-write state, so a simultaneous read+write returns the old value.
    rd_d = '0;
    for (int i = 0; i < N; i++) begin
      if (address == ADDR_WIDTH'(i)) rd_d = shadow_q[i];
    end
    if (address == STATUS_ADDR) rd_d = status;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        state_q[i]  <= IDLE;
        shadow_q[i] <= '0;
        data_q[i]   <= '0;
      end
      valid_q    <= '0;
      overrun_q  <= '0;
      readdata_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_en && address == ADDR_WIDTH'(i)) shadow_q[i] <= writedata;
        // Clear first so that a same-cycle overrun set below takes priority.
        if (ovr_clr[i]) overrun_q[i] <= 1'b0;
        case (state_q[i])
          IDLE: begin
            if (commit[i]) begin
              state_q[i] <= BUSY;
              valid_q[i] <= 1'b1;
              data_q[i]  <= shadow_q[i];
            end
          end
          BUSY: begin
            if (commit[i]) overrun_q[i] <= 1'b1;
            if (out_ack[i]) begin
              state_q[i] <= IDLE;
              valid_q[i] <= 1'b0;
            end
          end
          default: begin
            state_q[i] <= IDLE;
            valid_q[i] <= 1'b0;
          end
        endcase
      end
      if (rd_en) readdata_q <= rd_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
  end

  assign out_valid = valid_q;
  assign readdata  = readdata_q;

endmodule
